// File: rtl/aidan_mcnay_toggle_tx_if.sv
// Purpose : event/toggle bundle between an event source and the toggle
//           transmitter.
// Signals : event_in   - one event per cycle sampled high
//           out_signal - toggle line towards the change detector
//           pending    - queued events not yet toggled
//           busy       - transmitter holding the line or holding a backlog
//           overflow   - one-cycle pulse when an event is dropped
// Modports: master (event source side), slave (transmitter side).
interface aidan_mcnay_toggle_tx_if #(
    parameter int unsigned PEND_W = 4
);
    logic              event_in;
    logic              out_signal;
    logic [PEND_W-1:0] pending;
    logic              busy;
    logic              overflow;

    modport master (
        output event_in,
        input  out_signal,
        input  pending,
        input  busy,
        input  overflow
    );

    modport slave (
        input  event_in,
        output out_signal,
        output pending,
        output busy,
        output overflow
    );
endinterface

// File: rtl/aidan_mcnay_toggle_tx.sv
// Purpose : toggle-signalling transmitter. Each event flips out_signal once;
//           events arriving faster than HOLD_CYCLES spacing are queued in a
//           saturating backlog counter and replayed evenly spaced.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - aidan_mcnay_toggle_tx_if.slave (event_in in; out_signal,
//                   pending, busy, overflow out)
module aidan_mcnay_toggle_tx #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned PEND_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    aidan_mcnay_toggle_tx_if.slave   bus
);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX    = {PEND_W{1'b1}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [HOLD_W-1:0] r_hold,  w_hold_nxt;
    logic [PEND_W-1:0] r_pend,  w_pend_nxt;
    logic              r_out,   w_out_nxt;
    logic              r_ovf,   w_ovf_nxt;
    logic              w_ready;
    logic              w_toggle;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_pend  <= '0;
            r_out   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_pend  <= w_pend_nxt;
            r_out   <= w_out_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Next-state, toggle issue and backlog accounting
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_pend_nxt  = r_pend;
        w_out_nxt   = r_out;
        w_ovf_nxt   = 1'b0;

        // Spacing has expired once the hold counter reaches zero, so the next
        // toggle lands exactly HOLD_CYCLES edges after the previous one.
        w_ready  = (r_state == S_IDLE) || (r_hold == '0);
        w_toggle = w_ready && ((r_pend != '0) || bus.event_in);

        case (r_state)
            S_IDLE: begin
                if (w_toggle) begin
                    w_out_nxt   = ~r_out;
                    w_state_nxt = S_HOLD;
                    w_hold_nxt  = HOLD_RELOAD;
                end
            end
            S_HOLD: begin
                if (w_toggle) begin
                    w_out_nxt  = ~r_out;
                    w_hold_nxt = HOLD_RELOAD;
                end else if (r_hold == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hold_nxt = r_hold - HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A toggle with an empty backlog consumes event_in directly; with a
        // backlog it consumes one entry and a same-cycle event refills it.
        if (w_toggle) begin
            if ((r_pend != '0) && !bus.event_in) begin
                w_pend_nxt = r_pend - PEND_W'(1);
            end
        end else if (bus.event_in) begin
            if (r_pend == PEND_MAX) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_pend_nxt = r_pend + PEND_W'(1);
            end
        end
    end

    assign bus.out_signal = r_out;
    assign bus.pending    = r_pend;
    assign bus.overflow   = r_ovf;
    // Decoded from registers only; no path from event_in.
    assign bus.busy       = (r_state == S_HOLD) || (r_pend != '0);

endmodule

// File: tb/tb_aidan_mcnay_toggle_tx.sv
`timescale 1ns/1ps
module tb_aidan_mcnay_toggle_tx;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance 0: HOLD=2 PEND_W=4, instance 1: HOLD=8 PEND_W=2, instance 2: HOLD=1 PEND_W=4
    aidan_mcnay_toggle_tx_if #(.PEND_W(4)) if_a ();
    aidan_mcnay_toggle_tx_if #(.PEND_W(2)) if_b ();
    aidan_mcnay_toggle_tx_if #(.PEND_W(4)) if_c ();

    aidan_mcnay_toggle_tx #(.HOLD_CYCLES(2), .PEND_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    aidan_mcnay_toggle_tx #(.HOLD_CYCLES(8), .PEND_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    aidan_mcnay_toggle_tx #(.HOLD_CYCLES(1), .PEND_W(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    typedef struct {
        int   idx;
        logic out;
        int   pend;
        logic busy;
        logic ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    int   m_pend [N];
    int   m_last [N];
    logic m_out  [N];
    logic prev_obs [N];
    int   tog_cnt [N];
    int   ovf_cnt [N];
    int   det_cnt;
    int   last_det;

    function automatic int hold_of(input int i);
        case (i)
            0:       return 2;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int maxp_of(input int i);
        return (i == 1) ? 3 : 15;
    endfunction

    task automatic sample(input int i, output logic o, output int p, output logic b, output logic v);
        case (i)
            0: begin o = if_a.out_signal; p = int'(if_a.pending); b = if_a.busy; v = if_a.overflow; end
            1: begin o = if_b.out_signal; p = int'(if_b.pending); b = if_b.busy; v = if_b.overflow; end
            default: begin o = if_c.out_signal; p = int'(if_c.pending); b = if_c.busy; v = if_c.overflow; end
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i]   = 0;
            m_last[i]   = -1000;
            m_out[i]    = 1'b0;
            prev_obs[i] = 1'b0;
        end
        last_det = -1000;
    endtask

    // One clock: drive events, push model expectations, pop and compare after the edge
    task automatic step(input logic e0, input logic e1, input logic e2);
        logic ev [N];
        exp_t x;
        logic o, b, v;
        int   p;
        bit   tog;
        ev[0] = e0; ev[1] = e1; ev[2] = e2;
        @(negedge clk);
        if_a.event_in = e0;
        if_b.event_in = e1;
        if_c.event_in = e2;
        cyc++;
        for (int i = 0; i < N; i++) begin
            tog   = ((cyc - m_last[i]) >= hold_of(i)) && ((m_pend[i] != 0) || (ev[i] == 1'b1));
            x.idx = i;
            x.ovf = 1'b0;
            if (tog) begin
                m_out[i]  = ~m_out[i];
                m_last[i] = cyc;
                if ((m_pend[i] != 0) && !ev[i]) m_pend[i]--;
            end else if (ev[i]) begin
                if (m_pend[i] == maxp_of(i)) x.ovf = 1'b1;
                else m_pend[i]++;
            end
            x.out  = m_out[i];
            x.pend = m_pend[i];
            x.busy = (m_pend[i] != 0) || ((cyc - m_last[i]) < hold_of(i));
            sb_q.push_back(x);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            sample(x.idx, o, p, b, v);
            n_cmp++;
            if (o !== x.out) begin
                n_bad++;
                $display("FAIL out_signal[%0d] cyc %0d: got %b expected %b", x.idx, cyc, o, x.out);
            end
            n_cmp++;
            if (p !== x.pend) begin
                n_bad++;
                $display("FAIL pending[%0d] cyc %0d: got %0d expected %0d", x.idx, cyc, p, x.pend);
            end
            n_cmp++;
            if (b !== x.busy) begin
                n_bad++;
                $display("FAIL busy[%0d] cyc %0d: got %b expected %b", x.idx, cyc, b, x.busy);
            end
            n_cmp++;
            if (v !== x.ovf) begin
                n_bad++;
                $display("FAIL overflow[%0d] cyc %0d: got %b expected %b", x.idx, cyc, v, x.ovf);
            end
            if (o !== prev_obs[x.idx]) tog_cnt[x.idx]++;
            if (v === 1'b1) ovf_cnt[x.idx]++;
            // Change detector on instance 0: one pulse per line change
            if ((x.idx == 0) && (o !== prev_obs[0])) begin
                det_cnt++;
                n_cmp++;
                if ((cyc - last_det) < 2) begin
                    n_bad++;
                    $display("FAIL detect_spacing cyc %0d: got gap %0d expected >= 2", cyc, cyc - last_det);
                end
                last_det = cyc;
            end
            prev_obs[x.idx] = o;
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic o, b, v;
        int   p;
        for (int i = 0; i < N; i++) begin
            sample(i, o, p, b, v);
            n_cmp++;
            if ((o !== 1'b0) || (p !== 0) || (b !== 1'b0) || (v !== 1'b0)) begin
                n_bad++;
                $display("FAIL %s[%0d]: got out=%b pend=%0d busy=%b ovf=%b expected all 0", tag, i, o, p, b, v);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if_a.event_in = k[0];
            if_b.event_in = k[0];
            if_c.event_in = ~k[0];
            @(posedge clk);
            #1;
            check_all_zero("reset_hold");
        end
        @(negedge clk);
        if_a.event_in = 1'b0;
        if_b.event_in = 1'b0;
        if_c.event_in = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_event();
        int t0;
        t0 = tog_cnt[0];
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ((tog_cnt[0] - t0) !== 1) begin
            n_bad++;
            $display("FAIL single_event_toggles: got %0d expected 1", tog_cnt[0] - t0);
        end
    endtask

    task automatic test_back_to_back();
        int ta, tc;
        ta = tog_cnt[0];
        tc = tog_cnt[2];
        repeat (4) step(1'b1, 1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ((tog_cnt[0] - ta) !== 4) begin
            n_bad++;
            $display("FAIL burst_toggles_hold2: got %0d expected 4", tog_cnt[0] - ta);
        end
        n_cmp++;
        if ((tog_cnt[2] - tc) !== 4) begin
            n_bad++;
            $display("FAIL burst_toggles_hold1: got %0d expected 4", tog_cnt[2] - tc);
        end
    endtask

    task automatic test_overflow();
        int tb0, ob0;
        tb0 = tog_cnt[1];
        ob0 = ovf_cnt[1];
        repeat (6) step(1'b0, 1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ((tog_cnt[1] - tb0) !== 4) begin
            n_bad++;
            $display("FAIL overflow_toggles: got %0d expected 4", tog_cnt[1] - tb0);
        end
        n_cmp++;
        if ((ovf_cnt[1] - ob0) !== 2) begin
            n_bad++;
            $display("FAIL overflow_pulses: got %0d expected 2", ovf_cnt[1] - ob0);
        end
    endtask

    task automatic test_loopback();
        int gap;
        det_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 1'b0);
            gap = int'($urandom_range(0, 3));
            repeat (gap) step(1'b0, 1'b0, 1'b0);
        end
        repeat (60) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (det_cnt !== 20) begin
            n_bad++;
            $display("FAIL loopback_pulses: got %0d expected 20", det_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        repeat (4) step(1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(negedge clk);
        if_a.event_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_mid_hold");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        t0 = tog_cnt[0];
        repeat (8) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ((tog_cnt[0] - t0) !== 0) begin
            n_bad++;
            $display("FAIL post_reset_quiet: got %0d toggles expected 0", tog_cnt[0] - t0);
        end
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ((tog_cnt[0] - t0) !== 1) begin
            n_bad++;
            $display("FAIL post_reset_event: got %0d toggles expected 1", tog_cnt[0] - t0);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        if_a.event_in = 1'b0;
        if_b.event_in = 1'b0;
        if_c.event_in = 1'b0;
        det_cnt       = 0;
        for (int i = 0; i < N; i++) begin
            tog_cnt[i] = 0;
            ovf_cnt[i] = 0;
        end
        model_reset();
        test_reset();
        test_single_event();
        test_back_to_back();
        test_overflow();
        test_loopback();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
